flex_counter_multi: RTL and testbench

//  Multi-channel, parametrised successor of the single flexible counter. Each of NUM_CH channels

---
 rtl/flex_counter_pkg.sv | 12 +
 rtl/flex_counter_multi_if.sv | 28 ++
 rtl/flex_counter_chan.sv | 87 ++++++++
 rtl/flex_counter_multi.sv | 52 +++++
 tb/tb_flex_counter_multi.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flex_counter_pkg.sv
// Shared direction constants and slice helper for the
// multi-channel flexible counter.
package flex_counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/flex_counter_multi_if.sv
// Control and status bundle for flex_counter_multi; all
// per-channel fields are packed, channel i at [i*W +: W].
interface flex_counter_multi_if #(
    parameter int W      = 4,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]   clear;
    logic [NUM_CH-1:0]   count_enable;
    logic [NUM_CH-1:0]   count_down;
    logic [NUM_CH-1:0]   load;
    logic [NUM_CH*W-1:0] load_val;
    logic [NUM_CH*W-1:0] rollover_val;
    logic [NUM_CH*W-1:0] count_out;
    logic [NUM_CH-1:0]   rollover_flag;
    logic [NUM_CH-1:0]   wrap_pulse;

    modport master (
        output clear, count_enable, count_down, load,
        output load_val, rollover_val,
        input  count_out, rollover_flag, wrap_pulse
    );

    modport slave (
        input  clear, count_enable, count_down, load,
        input  load_val, rollover_val,
        output count_out, rollover_flag, wrap_pulse
    );
endinterface

// File: rtl/flex_counter_chan.sv
// One counter channel: count, terminal flag and wrap pulse
// registers; exports its wrap decision for cascading.
module flex_counter_chan
    import flex_counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         en_eff,
    input  logic         count_down,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count,
    output logic         flag,
    output logic         pulse,
    output logic         wrap_evt
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] step, term;
    logic         flag_q, flag_d;
    logic         pulse_q, pulse_d;
    logic         wrap, r_zero;

    always_comb begin
        term   = (count_down == DIR_DOWN) ? ONE : rollover_val;
        r_zero = (rollover_val == '0);
        step   = cnt_q;
        wrap   = 1'b0;
        if (r_zero) begin
            step = '0;
        end else if (count_down == DIR_DOWN) begin
            // leaving 0 (post-reset/clear) reloads R without a wrap
            if (cnt_q <= ONE) begin
                step = rollover_val;
                wrap = (cnt_q != '0);
            end else begin
                step = cnt_q - ONE;
            end
        end else if (cnt_q >= rollover_val) begin
            step = ONE;
            wrap = 1'b1;
        end else begin
            step = cnt_q + ONE;
        end
    end

    assign wrap_evt = en_eff & ~clear & ~load & wrap;

    always_comb begin
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        pulse_d = 1'b0;
        if (clear) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (load) begin
            cnt_d  = load_val;
            flag_d = !r_zero && (load_val == term);
        end else if (en_eff) begin
            cnt_d   = step;
            flag_d  = !r_zero && (step == term);
            pulse_d = wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    assign count = cnt_q;
    assign flag  = flag_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/flex_counter_multi.sv
// NUM_CH flexible counter channels with an optional wrap
// cascade; all state lives in the channel instances.
module flex_counter_multi
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2,
    parameter int CASCADE      = 0
) (
    input logic clk,
    input logic rst,
    flex_counter_multi_if.slave bus
);
    localparam int W = NUM_CNT_BITS;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic         en_w;
        logic         wrap_w;
        logic         flag_w;
        logic         pulse_w;
        logic [W-1:0] cnt_w;

        // each stage sees the previous stage's wrap in the same cycle
        if (CASCADE != 0 && i > 0) begin : g_casc
            assign en_w = bus.count_enable[i] & g_ch[i-1].wrap_w;
        end else begin : g_solo
            assign en_w = bus.count_enable[i];
        end

        flex_counter_chan #(
            .W(W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .clear       (bus.clear[i]),
            .load        (bus.load[i]),
            .en_eff      (en_w),
            .count_down  (bus.count_down[i]),
            .load_val    (bus.load_val[slice_lo(i, W) +: W]),
            .rollover_val(bus.rollover_val[slice_lo(i, W) +: W]),
            .count       (cnt_w),
            .flag        (flag_w),
            .pulse       (pulse_w),
            .wrap_evt    (wrap_w)
        );

        assign bus.count_out[slice_lo(i, W) +: W] = cnt_w;
        assign bus.rollover_flag[i]               = flag_w;
        assign bus.wrap_pulse[i]                  = pulse_w;
    end

endmodule

// File: tb/tb_flex_counter_multi.sv
// Bench for flex_counter_multi: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_flex_counter_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flex_counter_multi_if #(.W(4), .NUM_CH(3)) b0 ();
    flex_counter_multi_if #(.W(4), .NUM_CH(2)) b1 ();

    flex_counter_multi #(
        .NUM_CNT_BITS(4), .NUM_CH(3), .CASCADE(0)
    ) u0 (.clk(clk), .rst(rst), .bus(b0));

    flex_counter_multi #(
        .NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1)
    ) u1 (.clk(clk), .rst(rst), .bus(b1));

    int checks   = 0;
    int failures = 0;

    int m_cnt   [2][3];
    bit m_flag  [2][3];
    bit m_pulse [2][3];

    // d selects the model instance (0: independent, 1: cascaded)
    task automatic model_tick(input int d, input int nch, input bit casc,
                              input logic [2:0] clr, input logic [2:0] ce,
                              input logic [2:0] dn, input logic [2:0] ld,
                              input logic [11:0] lv, input logic [11:0] rv);
        bit prev_wrap;
        int r, c, l;
        bit en, w;
        prev_wrap = 1'b0;
        for (int i = 0; i < nch; i++) begin
            r  = int'(rv[i*4 +: 4]);
            l  = int'(lv[i*4 +: 4]);
            c  = m_cnt[d][i];
            en = ce[i] && (!casc || i == 0 || prev_wrap);
            w  = 1'b0;
            m_pulse[d][i] = 1'b0;
            if (clr[i]) begin
                m_cnt[d][i]  = 0;
                m_flag[d][i] = 1'b0;
            end else if (ld[i]) begin
                m_cnt[d][i]  = l;
                m_flag[d][i] = (r != 0) && (l == (dn[i] ? 1 : r));
            end else if (en) begin
                if (r == 0) begin
                    c = 0;
                end else if (dn[i]) begin
                    if (c <= 1) begin
                        w = (c == 1);
                        c = r;
                    end else begin
                        c = c - 1;
                    end
                end else if (c >= r) begin
                    c = 1;
                    w = 1'b1;
                end else begin
                    c = c + 1;
                end
                m_cnt[d][i]   = c;
                m_flag[d][i]  = (r != 0) && (c == (dn[i] ? 1 : r));
                m_pulse[d][i] = w;
            end
            prev_wrap = w;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) begin
                m_cnt[d][i]   = 0;
                m_flag[d][i]  = 1'b0;
                m_pulse[d][i] = 1'b0;
            end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick(0, 3, 1'b0, b0.clear, b0.count_enable, b0.count_down,
                   b0.load, b0.load_val, b0.rollover_val);
        model_tick(1, 2, 1'b1, {1'b0, b1.clear}, {1'b0, b1.count_enable},
                   {1'b0, b1.count_down}, {1'b0, b1.load},
                   {4'b0, b1.load_val}, {4'b0, b1.rollover_val});
        #1;
    endtask

    task automatic idle();
        b0.clear = '0; b0.count_enable = '0; b0.count_down = '0;
        b0.load = '0; b0.load_val = '0; b0.rollover_val = '0;
        b1.clear = '0; b1.count_enable = '0; b1.count_down = '0;
        b1.load = '0; b1.load_val = '0; b1.rollover_val = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        checks++;
        if (b0.count_out !== 12'h0 || b0.rollover_flag !== 3'b0 ||
            b0.wrap_pulse !== 3'b0) begin
            failures++;
            $display("FAIL reset_dut0 got cnt=%h flag=%b pulse=%b exp 0",
                     b0.count_out, b0.rollover_flag, b0.wrap_pulse);
        end
        checks++;
        if (b1.count_out !== 8'h0 || b1.rollover_flag !== 2'b0 ||
            b1.wrap_pulse !== 2'b0) begin
            failures++;
            $display("FAIL reset_dut1 got cnt=%h flag=%b pulse=%b exp 0",
                     b1.count_out, b1.rollover_flag, b1.wrap_pulse);
        end
    endtask

    task automatic test_up();
        int exp;
        idle();
        do_reset();
        b0.rollover_val[3:0] = 4'd5;
        b0.count_enable[0]   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp = (k % 5) + 1;
            checks++;
            if (b0.count_out[3:0] !== 4'(exp) ||
                b0.rollover_flag[0] !== (exp == 5) ||
                b0.wrap_pulse[0] !== (exp == 1 && k > 0)) begin
                failures++;
                $display("FAIL up k=%0d got cnt=%0d flag=%b pulse=%b exp cnt=%0d",
                         k, b0.count_out[3:0], b0.rollover_flag[0],
                         b0.wrap_pulse[0], exp);
            end
        end
    endtask

    task automatic test_down();
        int exp;
        idle();
        do_reset();
        b0.rollover_val[3:0] = 4'd4;
        b0.count_down[0]     = 1'b1;
        b0.count_enable[0]   = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp = 4 - (k % 4);
            checks++;
            if (b0.count_out[3:0] !== 4'(exp) ||
                b0.rollover_flag[0] !== (exp == 1) ||
                b0.wrap_pulse[0] !== (exp == 4 && k > 0)) begin
                failures++;
                $display("FAIL down k=%0d got cnt=%0d flag=%b pulse=%b exp cnt=%0d",
                         k, b0.count_out[3:0], b0.rollover_flag[0],
                         b0.wrap_pulse[0], exp);
            end
        end
    endtask

    task automatic test_priority();
        idle();
        do_reset();
        b0.rollover_val[7:4] = 4'd9;
        b0.count_enable[1]   = 1'b1;
        tick();
        tick();
        b0.clear[1] = 1'b1;
        b0.load[1] = 1'b1;
        b0.load_val[7:4] = 4'd7;
        tick();
        checks++;
        if (b0.count_out[7:4] !== 4'd0 || b0.rollover_flag[1] !== 1'b0) begin
            failures++;
            $display("FAIL prio_clear got cnt=%0d flag=%b exp cnt=0 flag=0",
                     b0.count_out[7:4], b0.rollover_flag[1]);
        end
        b0.clear[1] = 1'b0;
        tick();
        checks++;
        if (b0.count_out[7:4] !== 4'd7 || b0.wrap_pulse[1] !== 1'b0 ||
            b0.rollover_flag[1] !== 1'b0) begin
            failures++;
            $display("FAIL prio_load got cnt=%0d pulse=%b exp cnt=7 pulse=0",
                     b0.count_out[7:4], b0.wrap_pulse[1]);
        end
        b0.load_val[7:4] = 4'd9;
        tick();
        checks++;
        if (b0.count_out[7:4] !== 4'd9 || b0.rollover_flag[1] !== 1'b1) begin
            failures++;
            $display("FAIL load_term got cnt=%0d flag=%b exp cnt=9 flag=1",
                     b0.count_out[7:4], b0.rollover_flag[1]);
        end
        b0.load[1] = 1'b0;
    endtask

    task automatic test_boundary();
        b0.rollover_val[7:4] = 4'd0;
        b0.count_enable[1]   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (b0.count_out[7:4] !== 4'd0 || b0.rollover_flag[1] !== 1'b0 ||
                b0.wrap_pulse[1] !== 1'b0) begin
                failures++;
                $display("FAIL r_zero k=%0d got cnt=%0d flag=%b pulse=%b exp 0",
                         k, b0.count_out[7:4], b0.rollover_flag[1],
                         b0.wrap_pulse[1]);
            end
        end
        b0.rollover_val[7:4] = 4'd6;
        b0.load[1] = 1'b1;
        b0.load_val[7:4] = 4'd9;
        tick();
        b0.load[1] = 1'b0;
        tick();
        checks++;
        if (b0.count_out[7:4] !== 4'd1 || b0.wrap_pulse[1] !== 1'b1) begin
            failures++;
            $display("FAIL above_r got cnt=%0d pulse=%b exp cnt=1 pulse=1",
                     b0.count_out[7:4], b0.wrap_pulse[1]);
        end
        b0.rollover_val[7:4] = 4'd15;
        b0.load[1] = 1'b1;
        b0.load_val[7:4] = 4'd15;
        tick();
        b0.load[1] = 1'b0;
        tick();
        checks++;
        if (b0.count_out[7:4] !== 4'd1 || b0.wrap_pulse[1] !== 1'b1 ||
            b0.rollover_flag[1] !== 1'b0) begin
            failures++;
            $display("FAIL all_ones got cnt=%0d pulse=%b exp cnt=1 pulse=1",
                     b0.count_out[7:4], b0.wrap_pulse[1]);
        end
    endtask

    task automatic test_cascade();
        int npulse;
        int first;
        npulse = 0;
        first  = -1;
        idle();
        do_reset();
        b1.rollover_val = {4'd3, 4'd2};
        b1.count_enable = 2'b11;
        for (int k = 1; k <= 18; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (b1.count_out[i*4 +: 4] !== 4'(m_cnt[1][i]) ||
                    b1.rollover_flag[i] !== m_flag[1][i] ||
                    b1.wrap_pulse[i] !== m_pulse[1][i]) begin
                    failures++;
                    $display("FAIL cascade k=%0d ch%0d got cnt=%0d flag=%b pulse=%b exp cnt=%0d flag=%b pulse=%b",
                             k, i, b1.count_out[i*4 +: 4], b1.rollover_flag[i],
                             b1.wrap_pulse[i], m_cnt[1][i], m_flag[1][i],
                             m_pulse[1][i]);
                end
            end
            if (b1.wrap_pulse[1] === 1'b1) begin
                npulse++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (npulse != 2 || first != 9 || b1.count_out !== {4'd2, 4'd2}) begin
            failures++;
            $display("FAIL cascade_rate got pulses=%0d first=%0d cnt=%h exp pulses=2 first=9 cnt=22",
                     npulse, first, b1.count_out);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        do_reset();
        b0.rollover_val[3:0] = 4'd5;
        b0.count_enable[0]   = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (b0.count_out !== 12'h0 || b0.rollover_flag !== 3'b0 ||
            b0.wrap_pulse !== 3'b0) begin
            failures++;
            $display("FAIL async_rst got cnt=%h flag=%b pulse=%b exp 0",
                     b0.count_out, b0.rollover_flag, b0.wrap_pulse);
        end
        model_reset();
        #1 rst = 1'b0;
        tick();
        checks++;
        if (b0.count_out[3:0] !== 4'd1 || b0.wrap_pulse[0] !== 1'b0 ||
            b0.rollover_flag[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_resume got cnt=%0d pulse=%b exp cnt=1 pulse=0",
                     b0.count_out[3:0], b0.wrap_pulse[0]);
        end
    endtask

    task automatic test_random();
        idle();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                b0.clear[i]        = ($urandom_range(15) == 0);
                b0.load[i]         = ($urandom_range(9) == 0);
                b0.count_enable[i] = ($urandom_range(3) != 0);
                if ($urandom_range(7) == 0) b0.count_down[i] = ~b0.count_down[i];
                if ($urandom_range(15) == 0)
                    b0.rollover_val[i*4 +: 4] = 4'($urandom_range(15));
                b0.load_val[i*4 +: 4] = 4'($urandom_range(15));
            end
            for (int i = 0; i < 2; i++) begin
                b1.clear[i]        = ($urandom_range(31) == 0);
                b1.load[i]         = ($urandom_range(19) == 0);
                b1.count_enable[i] = ($urandom_range(3) != 0);
                if ($urandom_range(15) == 0) b1.count_down[i] = ~b1.count_down[i];
                if ($urandom_range(15) == 0)
                    b1.rollover_val[i*4 +: 4] = 4'($urandom_range(5));
                b1.load_val[i*4 +: 4] = 4'($urandom_range(15));
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (b0.count_out[i*4 +: 4] !== 4'(m_cnt[0][i]) ||
                    b0.rollover_flag[i] !== m_flag[0][i] ||
                    b0.wrap_pulse[i] !== m_pulse[0][i]) begin
                    failures++;
                    $display("FAIL rand0 k=%0d ch%0d got cnt=%0d flag=%b pulse=%b exp cnt=%0d flag=%b pulse=%b",
                             k, i, b0.count_out[i*4 +: 4], b0.rollover_flag[i],
                             b0.wrap_pulse[i], m_cnt[0][i], m_flag[0][i],
                             m_pulse[0][i]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (b1.count_out[i*4 +: 4] !== 4'(m_cnt[1][i]) ||
                    b1.rollover_flag[i] !== m_flag[1][i] ||
                    b1.wrap_pulse[i] !== m_pulse[1][i]) begin
                    failures++;
                    $display("FAIL rand1 k=%0d ch%0d got cnt=%0d flag=%b pulse=%b exp cnt=%0d flag=%b pulse=%b",
                             k, i, b1.count_out[i*4 +: 4], b1.rollover_flag[i],
                             b1.wrap_pulse[i], m_cnt[1][i], m_flag[1][i],
                             m_pulse[1][i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_up();
        test_down();
        test_priority();
        test_boundary();
        test_cascade();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
